// File: rtl/stack_datapath_p.sv
// Stacking-game datapath with its own sequencer: sweeps the active block,
// resolves drops against the block below, and tracks score, chances and level.
module stack_datapath_p #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int SCREEN_W  = 160,
    parameter int BLOCK_W0  = 40,
    parameter int BASE_Y    = 116,
    parameter int ROW_H     = 4,
    parameter int N_ROWS    = 20,
    parameter int CHANCES   = 10,
    parameter int SCORE_W   = 8,
    parameter int TICK_BASE = 500000,
    parameter int TICK_DEC  = 25000,
    parameter int LEVEL_MAX = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               drop,
    output logic [X_W-1:0]     x_pos,
    output logic [X_W-1:0]     width,
    output logic [Y_W-1:0]     y_pos,
    output logic [X_W-1:0]     prev_x,
    output logic [X_W-1:0]     prev_width,
    output logic               moving,
    output logic               placed,
    output logic               hit,
    output logic [3:0]         chances,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level,
    output logic               game_over,
    output logic               win
);

    localparam int CNT_W = $clog2(TICK_BASE + 1);
    localparam int ROW_W = $clog2(N_ROWS + 1);

    typedef enum logic [2:0] {IDLE, MOVE, RESOLVE, OVER, WIN} state_t;

    state_t             state_q;
    logic [X_W-1:0]     x_q, w_q, px_q, pw_q;
    logic [Y_W-1:0]     y_q;
    logic               dir_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         chances_q, level_q;
    logic [SCORE_W-1:0] score_q;
    logic [ROW_W-1:0]   rows_q;
    logic               placed_q, hit_q, over_q, win_q;

    logic [31:0]        period;
    logic               tick, start_ok, is_hit, exact;
    logic [X_W:0]       x_end, p_end, hi;
    logic [X_W-1:0]     lo, ovl;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_d, score_q4;
    logic [3:0]         level_d, chances_d;
    logic [ROW_W-1:0]   rows_d;

    always_comb begin
        period    = 32'(TICK_BASE) - 32'(level_q) * 32'(TICK_DEC);
        tick      = (32'(cnt_q) == period - 32'd1);
        start_ok  = start && (state_q == IDLE || state_q == OVER ||
                              state_q == WIN);
        x_end     = {1'b0, x_q} + {1'b0, w_q};
        p_end     = {1'b0, px_q} + {1'b0, pw_q};
        lo        = (x_q > px_q) ? x_q : px_q;
        hi        = (x_end < p_end) ? x_end : p_end;
        is_hit    = hi > {1'b0, lo};
        ovl       = X_W'(hi - {1'b0, lo});
        exact     = (x_q == px_q) && (w_q == pw_q);
        score_sum = {1'b0, score_q} + (exact ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        score_q4  = score_d >> 2;
        level_d   = (score_q4 > SCORE_W'(LEVEL_MAX)) ? 4'(LEVEL_MAX)
                                                     : score_q4[3:0];
        chances_d = (chances_q == 4'd0) ? 4'd0 : chances_q - 4'd1;
        rows_d    = rows_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn || start_ok) begin
            // Start from a terminal/idle state reuses the reset image.
            state_q   <= resetn ? MOVE : IDLE;
            x_q       <= '0;
            w_q       <= X_W'(BLOCK_W0);
            y_q       <= Y_W'(BASE_Y);
            px_q      <= X_W'((SCREEN_W - BLOCK_W0) / 2);
            pw_q      <= X_W'(BLOCK_W0);
            dir_q     <= 1'b1;
            cnt_q     <= '0;
            chances_q <= 4'(CHANCES);
            score_q   <= '0;
            level_q   <= '0;
            rows_q    <= '0;
            placed_q  <= 1'b0;
            hit_q     <= 1'b0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            placed_q <= 1'b0;
            hit_q    <= 1'b0;
            unique case (state_q)
                MOVE: begin
                    if (drop) begin
                        state_q <= RESOLVE;
                        cnt_q   <= '0;
                    end else if (tick) begin
                        cnt_q <= '0;
                        if (dir_q) begin
                            if (x_end == (X_W+1)'(SCREEN_W)) begin
                                dir_q <= 1'b0;
                                x_q   <= x_q - 1'b1;
                            end else begin
                                x_q <= x_q + 1'b1;
                            end
                        end else begin
                            if (x_q == '0) begin
                                dir_q <= 1'b1;
                                x_q   <= x_q + 1'b1;
                            end else begin
                                x_q <= x_q - 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESOLVE: begin
                    placed_q <= 1'b1;
                    hit_q    <= is_hit;
                    x_q      <= '0;
                    dir_q    <= 1'b1;
                    cnt_q    <= '0;
                    if (is_hit) begin
                        px_q    <= lo;
                        pw_q    <= ovl;
                        w_q     <= ovl;
                        score_q <= score_d;
                        level_q <= level_d;
                        y_q     <= y_q - Y_W'(ROW_H);
                        rows_q  <= rows_d;
                        if (rows_d == ROW_W'(N_ROWS)) begin
                            state_q <= WIN;
                            win_q   <= 1'b1;
                        end else begin
                            state_q <= MOVE;
                        end
                    end else begin
                        chances_q <= chances_d;
                        if (chances_d == 4'd0) begin
                            state_q <= OVER;
                            over_q  <= 1'b1;
                        end else begin
                            state_q <= MOVE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_pos      = x_q;
    assign width      = w_q;
    assign y_pos      = y_q;
    assign prev_x     = px_q;
    assign prev_width = pw_q;
    assign moving     = (state_q == MOVE);
    assign placed     = placed_q;
    assign hit        = hit_q;
    assign chances    = chances_q;
    assign score      = score_q;
    assign level      = level_q;
    assign game_over  = over_q;
    assign win        = win_q;

endmodule
